// File: rtl/vid_mem_arbiter.sv
// Shared burst-command arbiter: display line prefetch (deadline priority) vs frame writer (anti-starvation); optional ARB_STATS_EN counters.
// Latency: rd_req -> mem_cmd_valid in 2 cycles, grant/done pulses 1 cycle after the memory handshake; one IDLE cycle between bursts.
// Backpressure: command held stable on mem_cmd_ready=0 (no withdrawal); single burst outstanding until mem_done.
module vid_mem_arbiter #(
  parameter int AW         = 28,
  parameter int LW         = 8,
  parameter int FB_BASE    = 0,
  parameter int LINE_WORDS = 240,
  parameter int STARVE_MAX = 4
) (
  input  logic          pixel_clk,
  input  logic          sys_rst,
  input  logic          rd_req,
  input  logic [10:0]   rd_line,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [LW-1:0] wr_len,
  output logic          rd_grant,
  output logic          wr_grant,
  output logic          rd_done,
  output logic          rd_overrun,
  output logic          mem_cmd_valid,
  input  logic          mem_cmd_ready,
  output logic          mem_cmd_we,
  output logic [AW-1:0] mem_cmd_addr,
  output logic [LW-1:0] mem_cmd_len,
  input  logic          mem_done
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   stat_rd_cnt,
  output logic [31:0]   stat_wr_cnt,
  output logic [15:0]   stat_ovr_cnt,
  input  logic          stat_clr
`endif
);

  localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [AW-1:0] BASE_A     = AW'(FB_BASE);
  localparam logic [AW-1:0] STRIDE_A   = AW'(LINE_WORDS);
  localparam logic [LW-1:0] RD_LEN     = LW'(LINE_WORDS);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, WR_WAIT} state_t;

  state_t        state;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] starve_cnt;
  logic [AW-1:0] line_addr;
  logic          ovr_evt;
  logic          rd_acc;
  logic          wr_acc;

  assign line_addr = BASE_A + AW'(rd_line) * STRIDE_A;
  // A request landing together with the completing mem_done is the next line, not an overrun.
  assign ovr_evt   = rd_req && (rd_pend || state == RD_CMD || (state == RD_WAIT && !mem_done));
  assign rd_acc    = (state == RD_CMD) && mem_cmd_ready;
  assign wr_acc    = (state == WR_CMD) && mem_cmd_ready;

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      rd_pend       <= 1'b0;
      rd_addr       <= '0;
      starve_cnt    <= '0;
      rd_grant      <= 1'b0;
      wr_grant      <= 1'b0;
      rd_done       <= 1'b0;
      rd_overrun    <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_we    <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_len   <= '0;
    end else begin
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;
      rd_done  <= 1'b0;
      if (rd_req) begin
        rd_pend <= 1'b1;
        rd_addr <= line_addr;
        if (ovr_evt) rd_overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!wr_req) starve_cnt <= '0;
          if (wr_req && (!rd_pend || starve_cnt == STARVE_LIM)) begin
            state         <= WR_CMD;
            mem_cmd_valid <= 1'b1;
            mem_cmd_we    <= 1'b1;
            mem_cmd_addr  <= wr_addr;
            mem_cmd_len   <= wr_len;
          end else if (rd_pend) begin
            // A replacement line arriving this cycle is issued instead of the stale one.
            state         <= RD_CMD;
            mem_cmd_valid <= 1'b1;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= rd_req ? line_addr : rd_addr;
            mem_cmd_len   <= RD_LEN;
          end
        end
        RD_CMD: begin
          if (rd_acc) begin
            state         <= RD_WAIT;
            mem_cmd_valid <= 1'b0;
            rd_grant      <= 1'b1;
            if (!rd_req) rd_pend <= 1'b0;
            if (wr_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
          end
        end
        WR_CMD: begin
          if (wr_acc) begin
            state         <= WR_WAIT;
            mem_cmd_valid <= 1'b0;
            wr_grant      <= 1'b1;
            starve_cnt    <= '0;
          end
        end
        RD_WAIT: begin
          if (mem_done) begin
            state   <= IDLE;
            rd_done <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (mem_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge pixel_clk) begin
    if (sys_rst || stat_clr) begin
      stat_rd_cnt  <= '0;
      stat_wr_cnt  <= '0;
      stat_ovr_cnt <= '0;
    end else begin
      if (rd_acc) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (wr_acc) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (ovr_evt && stat_ovr_cnt != 16'hFFFF) stat_ovr_cnt <= stat_ovr_cnt + 16'd1;
    end
  end
`endif

endmodule
